// File: rtl/scara_pkg.sv
// Shared command codes, dispatcher FSM encodings and state_reg layout
// for the G-code command dispatcher.
package scara_pkg;

  localparam int STATE_REG_W = 5;

  typedef enum logic [3:0] {
    G00 = 4'd0,
    G01 = 4'd1,
    G20 = 4'd2,
    G21 = 4'd3,
    G90 = 4'd4,
    G91 = 4'd5,
    M2  = 4'd6,
    M6  = 4'd7,
    M72 = 4'd8
  } cmd_code_e;

  // Dispatcher FSM states, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Bit positions inside state_reg = {tool_change, raise_tool, absolute, inches, linear}.
  localparam int SR_LINEAR   = 0;
  localparam int SR_INCHES   = 1;
  localparam int SR_ABSOLUTE = 2;
  localparam int SR_RAISE    = 3;
  localparam int SR_TOOL     = 4;

  localparam logic [STATE_REG_W-1:0] STATE_REG_RST = 5'b00100;

endpackage

// File: rtl/gcode_command_dispatcher_if.sv
// Command-in / motion-request-out handshake bundle of the G-code dispatcher.
interface gcode_command_dispatcher_if #(
  parameter int COORD_W = 14,
  parameter int N_AXES  = 2
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [3:0]                  cmd_code;
  logic [N_AXES*COORD_W-1:0]   cmd_coord;
  logic                        block;
  logic                        controller_ready;
  logic                        move_valid;
  logic [N_AXES*COORD_W-1:0]   move_target;
  logic                        tool_req;

  modport master (
    output cmd_valid, cmd_code, cmd_coord, block, controller_ready,
    input  cmd_ready, move_valid, move_target, tool_req
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_coord, block, controller_ready,
    output cmd_ready, move_valid, move_target, tool_req
  );
endinterface

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with combinational head read and occupancy count.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full    = (count_r == FULL_CNT);
  assign empty   = (count_r == '0);
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];
  assign do_wr_s = wr_en && !full;
  assign do_rd_s = rd_en && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_wr_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_rd_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (do_wr_s) mem_r[wr_ptr_r] <= wr_data;
  end
endmodule

// File: rtl/gcode_command_dispatcher.sv
// Buffers G-code commands and dispatches them in order as motion or tool
// requests, tracking modal state (units, positioning mode, tool flags).
module gcode_command_dispatcher
  import scara_pkg::*;
#(
  parameter int COORD_W    = 14,
  parameter int N_AXES     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  gcode_command_dispatcher_if.slave     bus,
  output logic [STATE_REG_W-1:0]        state_reg,
  output logic                          program_done,
  output logic                          err_illegal,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW = N_AXES * COORD_W;
  localparam int EW = CW + 4;

  logic [1:0]             fsm_r;
  logic [3:0]             cur_code_r;
  logic [CW-1:0]          cur_coord_r;
  logic [CW-1:0]          target_r;
  logic [CW-1:0]          move_target_r;
  logic [CW-1:0]          next_target_s;
  logic [CW-1:0]          tool_target_s;
  logic [STATE_REG_W-1:0] state_reg_r;
  logic                   move_valid_r;
  logic                   tool_req_r;
  logic                   program_done_r;
  logic                   err_illegal_r;
  logic                   push_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   empty_s;
  logic [EW-1:0]          head_s;

  assign bus.cmd_ready   = !full_s && (fsm_r != ST_DONE);
  assign push_s          = bus.cmd_valid && bus.cmd_ready;
  assign pop_s           = (fsm_r == ST_IDLE) && !empty_s && !bus.block;
  assign bus.move_valid  = move_valid_r;
  assign bus.tool_req    = tool_req_r;
  assign bus.move_target = move_target_r;
  assign state_reg       = state_reg_r;
  assign program_done    = program_done_r;
  assign err_illegal     = err_illegal_r;

  cmd_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_s),
    .wr_data ({bus.cmd_coord, bus.cmd_code}),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (fifo_count)
  );

  // Per-axis target: absolute copy, or relative add wrapping modulo 2^COORD_W.
  always_comb begin
    next_target_s = '0;
    for (int a = 0; a < N_AXES; a++) begin
      if (state_reg_r[SR_ABSOLUTE]) begin
        next_target_s[a*COORD_W +: COORD_W] = cur_coord_r[a*COORD_W +: COORD_W];
      end else begin
        next_target_s[a*COORD_W +: COORD_W] = target_r[a*COORD_W +: COORD_W]
                                            + cur_coord_r[a*COORD_W +: COORD_W];
      end
    end
  end

  // Tool number rides on axis 0; the remembered position is left untouched.
  always_comb begin
    tool_target_s                = target_r;
    tool_target_s[COORD_W-1:0]   = cur_coord_r[COORD_W-1:0];
  end

  // Dispatch FSM: pop, decode for one cycle, then hold the request until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_r          <= ST_IDLE;
      cur_code_r     <= 4'd0;
      cur_coord_r    <= '0;
      target_r       <= '0;
      move_target_r  <= '0;
      state_reg_r    <= STATE_REG_RST;
      move_valid_r   <= 1'b0;
      tool_req_r     <= 1'b0;
      program_done_r <= 1'b0;
      err_illegal_r  <= 1'b0;
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          if (pop_s) begin
            cur_code_r  <= head_s[3:0];
            cur_coord_r <= head_s[EW-1:4];
            fsm_r       <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (cur_code_r)
            G20: begin state_reg_r[SR_INCHES]   <= 1'b1; fsm_r <= ST_IDLE; end
            G21: begin state_reg_r[SR_INCHES]   <= 1'b0; fsm_r <= ST_IDLE; end
            G90: begin state_reg_r[SR_ABSOLUTE] <= 1'b1; fsm_r <= ST_IDLE; end
            G91: begin state_reg_r[SR_ABSOLUTE] <= 1'b0; fsm_r <= ST_IDLE; end
            M72: begin state_reg_r[SR_RAISE]    <= 1'b1; fsm_r <= ST_IDLE; end
            G00, G01: begin
              target_r                 <= next_target_s;
              move_target_r            <= next_target_s;
              state_reg_r[SR_LINEAR]   <= cur_code_r[0];
              state_reg_r[SR_RAISE]    <= 1'b0;
              state_reg_r[SR_TOOL]     <= 1'b0;
              move_valid_r             <= 1'b1;
              fsm_r                    <= ST_ISSUE;
            end
            M6: begin
              state_reg_r[SR_TOOL] <= 1'b1;
              move_target_r        <= tool_target_s;
              tool_req_r           <= 1'b1;
              fsm_r                <= ST_ISSUE;
            end
            M2: begin
              program_done_r <= 1'b1;
              fsm_r          <= ST_DONE;
            end
            default: begin
              err_illegal_r <= 1'b1;
              fsm_r         <= ST_IDLE;
            end
          endcase
        end
        ST_ISSUE: begin
          if (bus.controller_ready) begin
            move_valid_r <= 1'b0;
            tool_req_r   <= 1'b0;
            fsm_r        <= ST_IDLE;
          end
        end
        ST_DONE: fsm_r <= ST_DONE;
        default: fsm_r <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcode_command_dispatcher.sv
// Directed table-driven bench for gcode_command_dispatcher (COORD_W=14, 2 axes, depth 4).
module tb_gcode_command_dispatcher;

  logic       clk;
  logic       reset;
  logic [4:0] state_reg;
  logic       program_done;
  logic       err_illegal;
  logic [2:0] fifo_count;
  int         n_vec;
  int         n_err;

  gcode_command_dispatcher_if #(.COORD_W(14), .N_AXES(2)) bus ();

  gcode_command_dispatcher #(
    .COORD_W    (14),
    .N_AXES     (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .state_reg    (state_reg),
    .program_done (program_done),
    .err_illegal  (err_illegal),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [13:0] x;
    logic [13:0] y;
    int          exp_moves;
    logic [13:0] ex;
    logic [13:0] ey;
    logic [4:0]  exp_sr;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] code, input logic [27:0] coord);
    int w;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = code;
    bus.cmd_coord = coord;
    w = 0;
    while (!bus.cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.cmd_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: cmd_ready got 0, expected 1 for code %0d", code);
      bus.cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_move(input string name);
    int w;
    w = 0;
    while (!bus.move_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    check(name, 32'(bus.move_valid), 32'd1);
  endtask

  task automatic run_vec(input int idx);
    int          moves;
    logic [27:0] tgt;
    push(vecs[idx].code, {vecs[idx].y, vecs[idx].x});
    moves = 0;
    tgt   = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.move_valid) begin
        moves++;
        tgt = bus.move_target;
      end
    end
    if (moves == 0) tgt = bus.move_target;
    check($sformatf("v%0d_moves", idx), 32'(moves), 32'(vecs[idx].exp_moves));
    check($sformatf("v%0d_target", idx), 32'(tgt), 32'({vecs[idx].ey, vecs[idx].ex}));
    check($sformatf("v%0d_state_reg", idx), 32'(state_reg), 32'(vecs[idx].exp_sr));
    check($sformatf("v%0d_err", idx), 32'(err_illegal), 32'(vecs[idx].exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    logic [27:0] seen [4];

    n_vec = 0;
    n_err = 0;
    bus.cmd_valid        = 1'b0;
    bus.cmd_code         = 4'd0;
    bus.cmd_coord        = 28'd0;
    bus.block            = 1'b0;
    bus.controller_ready = 1'b1;

    // code, x, y, moves, exp x, exp y, state_reg, err
    vecs[0]  = '{4'd4,  14'd0,     14'd0,   0, 14'd0,   14'd0,   5'b00100, 1'b0}; // G90
    vecs[1]  = '{4'd1,  14'd100,   14'd200, 1, 14'd100, 14'd200, 5'b00101, 1'b0}; // G01 abs
    vecs[2]  = '{4'd5,  14'd0,     14'd0,   0, 14'd100, 14'd200, 5'b00001, 1'b0}; // G91
    vecs[3]  = '{4'd0,  14'd10,    14'd5,   1, 14'd110, 14'd205, 5'b00000, 1'b0}; // G00 rel
    vecs[4]  = '{4'd0,  14'd16383, 14'd0,   1, 14'd109, 14'd205, 5'b00000, 1'b0}; // wrap
    vecs[5]  = '{4'd2,  14'd0,     14'd0,   0, 14'd109, 14'd205, 5'b00010, 1'b0}; // G20
    vecs[6]  = '{4'd8,  14'd0,     14'd0,   0, 14'd109, 14'd205, 5'b01010, 1'b0}; // M72
    vecs[7]  = '{4'd1,  14'd1,     14'd1,   1, 14'd110, 14'd206, 5'b00011, 1'b0}; // G01 rel
    vecs[8]  = '{4'd3,  14'd0,     14'd0,   0, 14'd110, 14'd206, 5'b00001, 1'b0}; // G21
    vecs[9]  = '{4'd4,  14'd0,     14'd0,   0, 14'd110, 14'd206, 5'b00101, 1'b0}; // G90
    vecs[10] = '{4'd0,  14'd7,     14'd8,   1, 14'd7,   14'd8,   5'b00100, 1'b0}; // G00 abs
    vecs[11] = '{4'd12, 14'd0,     14'd0,   0, 14'd7,   14'd8,   5'b00100, 1'b1}; // illegal
    vecs[12] = '{4'd1,  14'd20,    14'd30,  1, 14'd20,  14'd30,  5'b00101, 1'b1}; // G01 after err

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_state_reg",    32'(state_reg),       32'd4);
    check("rst_move_valid",   32'(bus.move_valid),  32'd0);
    check("rst_tool_req",     32'(bus.tool_req),    32'd0);
    check("rst_move_target",  32'(bus.move_target), 32'd0);
    check("rst_fifo_count",   32'(fifo_count),      32'd0);
    check("rst_program_done", 32'(program_done),    32'd0);
    check("rst_err_illegal",  32'(err_illegal),     32'd0);
    check("rst_cmd_ready",    32'(bus.cmd_ready),   32'd1);

    for (int i = 0; i < 13; i++) run_vec(i);

    // Fill the buffer while blocked, then release and expect in-order dispatch.
    bus.block = 1'b1;
    for (int k = 1; k <= 4; k++) push(4'd0, {14'(k), 14'(k)});
    @(negedge clk);
    check("full_cmd_ready",  32'(bus.cmd_ready),  32'd0);
    check("full_fifo_count", 32'(fifo_count),     32'd4);
    check("blocked_no_move", 32'(bus.move_valid), 32'd0);
    bus.block = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.move_valid && cnt < 4) begin
        seen[cnt] = bus.move_target;
        cnt++;
      end
    end
    check("drain_count", 32'(cnt), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < cnt) check($sformatf("drain_order%0d", k), 32'(seen[k]), 32'({14'(k+1), 14'(k+1)}));
    end

    // Tool change held for five cycles of controller back-pressure.
    bus.controller_ready = 1'b0;
    push(4'd7, {14'd0, 14'd3});
    cnt = 0;
    while (!bus.tool_req && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("tool_req_hold%0d", c), 32'(bus.tool_req), 32'd1);
      check($sformatf("tool_num_hold%0d", c), 32'(bus.move_target[13:0]), 32'd3);
    end
    check("tool_state_reg", 32'(state_reg), 32'b10100);
    bus.controller_ready = 1'b1;
    @(negedge clk);
    check("tool_req_drop", 32'(bus.tool_req), 32'd0);

    // A modal code queued behind a stalled move must wait for that move.
    bus.controller_ready = 1'b0;
    push(4'd1, {14'd60, 14'd50});
    push(4'd5, 28'd0);
    wait_move("modal_move_seen");
    repeat (3) @(negedge clk);
    check("modal_move_held",   32'(bus.move_valid),  32'd1);
    check("modal_target",      32'(bus.move_target), 32'({14'd60, 14'd50}));
    check("modal_not_applied", 32'(state_reg),       32'b00101);
    bus.controller_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("modal_applied",     32'(state_reg),       32'b00001);

    // Reset with a move pending and two entries buffered.
    bus.controller_ready = 1'b0;
    push(4'd0, {14'd9, 14'd9});
    wait_move("pre_reset_move");
    push(4'd0, {14'd1, 14'd1});
    push(4'd0, {14'd1, 14'd1});
    @(negedge clk);
    check("pre_reset_count", 32'(fifo_count),     32'd2);
    check("pre_reset_valid", 32'(bus.move_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_move_valid",   32'(bus.move_valid),  32'd0);
    check("mid_rst_tool_req",     32'(bus.tool_req),    32'd0);
    check("mid_rst_target",       32'(bus.move_target), 32'd0);
    check("mid_rst_state_reg",    32'(state_reg),       32'd4);
    check("mid_rst_fifo_count",   32'(fifo_count),      32'd0);
    check("mid_rst_program_done", 32'(program_done),    32'd0);
    check("mid_rst_err",          32'(err_illegal),     32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.controller_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.move_valid) cnt++;
    end
    check("no_reissue", 32'(cnt), 32'd0);
    check("post_rst_count", 32'(fifo_count), 32'd0);

    // M2 ends the program: no more accepts until reset.
    push(4'd6, 28'd0);
    repeat (4) @(negedge clk);
    check("done_flag",      32'(program_done),  32'd1);
    check("done_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = 4'd1;
    bus.cmd_coord = {14'd5, 14'd5};
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.move_valid) cnt++;
    end
    bus.cmd_valid = 1'b0;
    check("done_no_move",   32'(cnt),          32'd0);
    check("done_no_buffer", 32'(fifo_count),   32'd0);
    check("done_sticky",    32'(program_done), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("done_cleared",  32'(program_done),  32'd0);
    check("ready_restore", 32'(bus.cmd_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gcode_command_dispatcher.md
GCODE_COMMAND_DISPATCHER -- requirements
Module: gcode_command_dispatcher

Interface
REQ-001 SHALL have parameter COORD_W, default 14, meaning coordinate width in bits.
REQ-002 SHALL have parameter N_AXES, default 2, meaning number of coordinate axes per command.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning command buffer entries (power of 2, >=2).
REQ-004 clk  in  1  the single clock; all state is updated on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  memory presents a command.
REQ-007 cmd_ready  out  1  buffer can accept; high when FIFO not full and state != DONE.
REQ-008 cmd_code  in  4  cmd_code_e: G00=0, G01=1, G20=2, G21=3, G90=4, G91=5, M2=6, M6=7, M72=8.
REQ-009 cmd_coord  in  N_AXES*COORD_W  packed axis values, axis 0 in LSBs.
REQ-010 block  in  1  holds dispatch while high; buffering continues.
REQ-011 controller_ready  in  1  motion controller accepts a move/tool request.
REQ-012 move_valid  out  1  move_target/move_linear valid; held until controller_ready.
REQ-013 move_target  out  N_AXES*COORD_W  absolute target per axis.
REQ-014 tool_req  out  1  tool-change request; held until controller_ready; tool number on axis 0 of move_target.
REQ-015 state_reg  out  5  {tool_change, raise_tool, absolute, inches, linear}.
REQ-016 program_done  out  1  M2 dispatched.
REQ-017 err_illegal  out  1  sticky: code > 8 dispatched.
REQ-018 fifo_count  out  $clog2(FIFO_DEPTH)+1  buffered entries.

Function
REQ-019 Handshake: entry written when cmd_valid && cmd_ready; no write when full; simultaneous write+read at full is not allowed (cmd_ready low).
REQ-020 FSM states IDLE, DECODE, ISSUE, DONE.
REQ-021 IDLE -> DECODE when FIFO non-empty and block low; head popped on this transition.
REQ-022 DECODE, one cycle: G20/G21/G90/G91 update inches/absolute and return IDLE; M72 sets raise_tool, returns IDLE; G00/G01 compute target, set linear=code[0], clear raise_tool and tool_change, go ISSUE; M6 sets tool_change, go ISSUE; M2 go DONE; illegal sets err_illegal, returns IDLE.
REQ-023 Target: absolute=1 -> target = coord; absolute=0 -> target = previous target + coord per axis, modulo 2^COORD_W (wrap, no saturation).
REQ-024 ISSUE: assert move_valid (G00/G01) or tool_req (M6); leave to IDLE on cycle controller_ready is high; outputs stable while waiting; block does not cancel an issued request.
REQ-025 Modal latency: state_reg reflects a modal code 2 cycles after IDLE pop; move_valid earliest 2 cycles after pop.
REQ-026 Commands are dispatched strictly in FIFO order; FIFO read and write pointers wrap modulo FIFO_DEPTH.
REQ-027 DONE: program_done=1, cmd_ready=0, no further pops; exits only by reset.
REQ-028 A modal code following a move takes effect only after that move's ISSUE completes.

Reset
REQ-029 reset SHALL immediately force IDLE, FIFO empty, fifo_count=0, move_valid=0, tool_req=0, move_target=0, state_reg=5'b00100 (absolute, mm, rapid), program_done=0, err_illegal=0.
REQ-030 reset mid-ISSUE or with entries buffered discards them; no request is re-issued after release.

Structure
REQ-031 cmd_code_e and FSM state enum SHALL live in shared package scara_pkg with STATE_REG_W=5.
REQ-032 FIFO SHALL be sub-module cmd_fifo (parametrised width/depth, count output).

Verification
REQ-033 G90, then G01 (100,200), controller_ready=1 -> move_valid one cycle, target (100,200), state_reg linear=1, absolute=1.
REQ-034 G91, G00 (10,5) from target (100,200) -> target (110,205), linear=0; then G00 (16383,0) with COORD_W=14 -> axis 0 wraps to 109.
REQ-035 Fill 4 entries with block=1 -> cmd_ready=0, fifo_count=4; release block -> all 4 dispatched in order.
REQ-036 M6 coord 3, controller_ready low 5 cycles -> tool_req high, target[0]=3 stable all 5 cycles, drops after ready.
REQ-037 Code 12 -> err_illegal sticky, next G01 dispatches normally; M2 -> program_done=1, cmd_ready=0 until reset.
REQ-038 reset asserted while move_valid high and FIFO holds 2 -> all outputs reset values same cycle, fifo_count=0.
